// File: rtl/btn_pkg.sv
// Shared types for the push-button input front end: event kinds, pending-slot
// ordering used by the arbiter, and the drop counter width.
package btn_pkg;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'd0,
        EV_RELEASE = 2'd1,
        EV_REPEAT  = 2'd2
    } ev_kind_t;

    localparam int unsigned DROP_CNT_W = 8;

    // Pending slot index doubles as arbitration priority within a button.
    localparam int unsigned SLOT_REL = 0;
    localparam int unsigned SLOT_PRS = 1;
    localparam int unsigned SLOT_REP = 2;
    localparam int unsigned N_SLOT   = 3;

    function automatic int unsigned code_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic ev_kind_t slot_kind(input int unsigned slot);
        case (slot)
            SLOT_REL: return EV_RELEASE;
            SLOT_PRS: return EV_PRESS;
            default:  return EV_REPEAT;
        endcase
    endfunction

endpackage

// File: rtl/btn_input_if.sv
// Valid/ready event port of btn_input: head-of-queue button code and kind.
interface btn_input_if #(
    parameter int unsigned CODE_W = 3
) ();

    logic              ev_valid;
    logic              ev_ready;
    logic [CODE_W-1:0] ev_code;
    btn_pkg::ev_kind_t ev_kind;

    modport master (output ev_valid, output ev_code, output ev_kind, input ev_ready);
    modport slave  (input ev_valid, input ev_code, input ev_kind, output ev_ready);

endinterface

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, debounce counter, stable level and
// raise strobes. Auto-repeat hold counter exists only with BTN_REPEAT_EN.
module btn_chan #(
    parameter int unsigned DEBOUNCE_CYC  = 4
`ifdef BTN_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = 20,
    parameter int unsigned REPEAT_PERIOD = 8
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic st,
    output logic press_o,
    output logic rel_o,
    output logic rep_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);

    logic             sync1_q, sync1_d;
    logic             s_q, s_d;
    logic             st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit;

    always_comb begin
        sync1_d = btn_raw;
        s_d     = sync1_q;
        st_d    = st_q;
        cnt_d   = '0;
        commit  = 1'b0;
        if (s_q != st_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                commit = 1'b1;
                st_d   = s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_o = commit && s_q;
        rel_o   = commit && !s_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            st_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            s_q     <= s_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
        end
    end

    assign st = st_q;

`ifdef BTN_REPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_lim;
    logic              first_q, first_d;

    // first_q selects the initial delay; after the first repeat the period applies.
    always_comb begin
        hold_lim = first_q ? HOLD_W'(REPEAT_DELAY - 1) : HOLD_W'(REPEAT_PERIOD - 1);
        hold_d   = hold_q;
        first_d  = first_q;
        rep_o    = 1'b0;
        if (press_o || rel_o || !st_q) begin
            hold_d  = '0;
            first_d = 1'b1;
        end else if (hold_q == hold_lim) begin
            rep_o   = 1'b1;
            hold_d  = '0;
            first_d = 1'b0;
        end else begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            first_q <= 1'b1;
        end else begin
            hold_q  <= hold_d;
            first_q <= first_d;
        end
    end
`else
    assign rep_o = 1'b0;
`endif

endmodule

// File: rtl/btn_input.sv
// Debounced push-button front end: per-button channels, pending event bits,
// fixed-priority arbiter, show-ahead event FIFO. Auto-repeat: BTN_REPEAT_EN.
module btn_input
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN         = 5,
    parameter int unsigned DEBOUNCE_CYC  = 50000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_BTN-1:0]      btn,
    output logic [N_BTN-1:0]      state,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    btn_input_if.master           ev
);

    localparam int unsigned CODE_W = code_w(N_BTN);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned SUM_W  = DROP_CNT_W + 6;
    localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'((1 << DROP_CNT_W) - 1);

    if (N_BTN < 1 || N_BTN > 8 || DEBOUNCE_CYC < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("btn_input: illegal parameter set");
    end

    typedef struct packed {
        logic [CODE_W-1:0] code;
        ev_kind_t          kind;
    } ev_t;

    logic [N_BTN-1:0] rel_s, prs_s, rep_s;

    for (genvar b = 0; b < N_BTN; b++) begin : g_chan
        btn_chan #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC)
`ifdef BTN_REPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn[b]),
            .st      (state[b]),
            .press_o (prs_s[b]),
            .rel_o   (rel_s[b]),
            .rep_o   (rep_s[b])
        );
    end

    logic [N_BTN-1:0][N_SLOT-1:0] pend_q, pend_d;
    logic [N_BTN-1:0][N_SLOT-1:0] raise, gnt;
    logic [DROP_CNT_W-1:0]        drop_q, drop_d;
    logic [PTR_W:0]               wr_q, wr_d, rd_q, rd_d, occ;
    ev_t                          mem_q [FIFO_DEPTH];
    ev_t                          mem_d [FIFO_DEPTH];
    ev_t                          push_ev;
    logic                         fifo_full, ev_valid_w, pop, push, can_push;
    logic [5:0]                   ndrop;
    logic [SUM_W-1:0]             drop_sum;

    always_comb begin
        occ        = wr_q - rd_q;
        fifo_full  = occ[PTR_W];
        ev_valid_w = (occ != '0);
        pop        = ev_valid_w && ev.ev_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        can_push   = !fifo_full || pop;

        gnt     = '0;
        push    = 1'b0;
        push_ev = '{code: '0, kind: EV_PRESS};
        for (int unsigned b = 0; b < N_BTN; b++) begin
            raise[b][SLOT_REL] = rel_s[b];
            raise[b][SLOT_PRS] = prs_s[b];
            raise[b][SLOT_REP] = rep_s[b];
            for (int unsigned k = 0; k < N_SLOT; k++) begin
                if (can_push && !push && pend_q[b][k]) begin
                    push         = 1'b1;
                    gnt[b][k]    = 1'b1;
                    push_ev.code = CODE_W'(b);
                    push_ev.kind = slot_kind(k);
                end
            end
        end

        // A bit granted this cycle is free to take a new raise without a drop.
        ndrop  = '0;
        pend_d = '0;
        for (int unsigned b = 0; b < N_BTN; b++) begin
            for (int unsigned k = 0; k < N_SLOT; k++) begin
                pend_d[b][k] = (pend_q[b][k] && !gnt[b][k]) || raise[b][k];
                if (raise[b][k] && pend_q[b][k] && !gnt[b][k]) begin
                    ndrop = ndrop + 6'd1;
                end
            end
`ifndef BTN_REPEAT_EN
            pend_d[b][SLOT_REP] = 1'b0;
`endif
        end

        drop_sum = SUM_W'(drop_q) + SUM_W'(ndrop);
        drop_d   = (drop_sum > DROP_MAX) ? '1 : drop_sum[DROP_CNT_W-1:0];

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q[PTR_W-1:0]] = push_ev;
        end
        wr_d = wr_q + (PTR_W + 1)'(push);
        rd_d = rd_q + (PTR_W + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            drop_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ev.ev_valid = ev_valid_w;
    assign ev.ev_code  = mem_q[rd_q[PTR_W-1:0]].code;
    assign ev.ev_kind  = mem_q[rd_q[PTR_W-1:0]].kind;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_btn_input.sv
// Bench for btn_input: directed scenarios plus random button activity, every
// cycle compared against an event-level reference model.
module tb_btn_input;
    import btn_pkg::*;

    localparam int unsigned N  = 5;
    localparam int unsigned DEB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;
    localparam int unsigned FD = 4;
    localparam int unsigned CW = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic         ready;
    logic [N-1:0] state;
    logic [7:0]   drop_cnt;

    btn_input_if #(.CODE_W(CW)) ev_if ();
    assign ev_if.ev_ready = ready;

    btn_input #(
        .N_BTN         (N),
        .DEBOUNCE_CYC  (DEB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .state    (state),
        .drop_cnt (drop_cnt),
        .ev       (ev_if.master)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct { int code; int kind; } mev_t;

    // Reference: raw level delayed two samples, run length of disagreement,
    // hold age since press, pending flags per kind, event queue.
    bit   m_sy1 [N];
    bit   m_s   [N];
    bit   m_st  [N];
    int   m_run [N];
    int   m_age [N];
    bit   m_pend[N][3];   // 0 = release, 1 = press, 2 = repeat (arbiter order)
    mev_t m_fifo[$];
    int   m_drop;
    int   tmr   [N];

    function automatic int kind_of(input int slot);
        return (slot == 0) ? 1 : (slot == 1) ? 0 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < N; b++) begin
            m_sy1[b] = 0; m_s[b] = 0; m_st[b] = 0; m_run[b] = 0; m_age[b] = 0;
            for (int k = 0; k < 3; k++) m_pend[b][k] = 0;
        end
        m_fifo.delete();
        m_drop = 0;
    endtask

    task automatic model_edge(input bit r, input logic [N-1:0] b_in, input bit rdy);
        bit pop, canp, commit;
        int gb, gk;
        bit rs[N][3];
        if (r) begin
            model_reset();
            return;
        end
        pop  = (m_fifo.size() > 0) && rdy;
        canp = (m_fifo.size() < FD) || pop;
        gb = -1; gk = -1;
        if (canp)
            for (int b = 0; b < N; b++)
                for (int k = 0; k < 3; k++)
                    if (m_pend[b][k] && gb < 0) begin gb = b; gk = k; end
        for (int b = 0; b < N; b++) begin
            commit   = (m_s[b] != m_st[b]) && (m_run[b] == DEB - 1);
            rs[b][0] = commit && !m_s[b];
            rs[b][1] = commit && m_s[b];
            rs[b][2] = 0;
`ifdef BTN_REPEAT_EN
            rs[b][2] = m_st[b] && !commit && (m_age[b] + 1 >= RD) && ((m_age[b] + 1 - RD) % RP == 0);
`endif
        end
        if (pop) void'(m_fifo.pop_front());
        if (gb >= 0) begin
            m_fifo.push_back('{code: gb, kind: kind_of(gk)});
            m_pend[gb][gk] = 0;
        end
        for (int b = 0; b < N; b++)
            for (int k = 0; k < 3; k++)
                if (rs[b][k]) begin
                    if (m_pend[b][k]) begin
                        if (m_drop < 255) m_drop++;
                    end else begin
                        m_pend[b][k] = 1;
                    end
                end
        for (int b = 0; b < N; b++) begin
            commit = (m_s[b] != m_st[b]) && (m_run[b] == DEB - 1);
            if (commit) begin
                m_st[b] = m_s[b]; m_run[b] = 0; m_age[b] = 0;
            end else begin
                m_run[b] = (m_s[b] != m_st[b]) ? m_run[b] + 1 : 0;
                if (m_st[b]) m_age[b]++;
            end
            m_s[b]   = m_sy1[b];
            m_sy1[b] = b_in[b];
        end
    endtask

    task automatic check_all();
        logic [N-1:0] es;
        for (int b = 0; b < N; b++) es[b] = m_st[b];
        chk("state", 32'(state), 32'(es));
        chk("ev_valid", 32'(ev_if.ev_valid), 32'(m_fifo.size() > 0));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (m_fifo.size() > 0) begin
            chk("ev_code", 32'(ev_if.ev_code), 32'(m_fifo[0].code));
            chk("ev_kind", 32'(ev_if.ev_kind), 32'(m_fifo[0].kind));
        end
    endtask

    task automatic step();
        bit r, rd;
        logic [N-1:0] b;
        r = rst; b = btn; rd = ready;
        @(posedge clk);
        #1;
        model_edge(r, b, rd);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct { int code; int kind; } exp_t;
    exp_t drain_exp [14] = '{
        '{0,0}, '{1,0}, '{2,0}, '{3,0}, '{0,1}, '{0,0}, '{1,1},
        '{1,0}, '{2,1}, '{2,0}, '{3,1}, '{3,0}, '{4,1}, '{4,0}};

    initial begin
        int rep_cnt, rep_first;
        rst = 1'b1; btn = '0; ready = 1'b1;
        model_reset();
        run(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid", 32'(ev_if.ev_valid), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        run(3);

        // Single press/release on button 2 with exact latency.
        btn[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("b2_pre", 32'(state[2]), 32'd0);
        end
        step();
        chk("b2_commit", 32'(state[2]), 32'd1);
        chk("b2_nov", 32'(ev_if.ev_valid), 32'd0);
        step();
        chk("b2_pv", 32'(ev_if.ev_valid), 32'd1);
        chk("b2_pcode", 32'(ev_if.ev_code), 32'd2);
        chk("b2_pkind", 32'(ev_if.ev_kind), 32'd0);
        run(2);
        btn[2] = 1'b0;
        run(6);
        chk("b2_rel_state", 32'(state[2]), 32'd0);
        step();
        chk("b2_rv", 32'(ev_if.ev_valid), 32'd1);
        chk("b2_rcode", 32'(ev_if.ev_code), 32'd2);
        chk("b2_rkind", 32'(ev_if.ev_kind), 32'd1);
        run(3);

        // Glitch shorter than the debounce window.
        btn[0] = 1'b1;
        run(3);
        btn[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("glitch_nov", 32'(ev_if.ev_valid), 32'd0);
        end
        chk("glitch_state", 32'(state), 32'd0);
        chk("glitch_drop", 32'(drop_cnt), 32'd0);

        // Hold button 1 for 40 cycles after commit.
        btn[1] = 1'b1;
        run(6);
        chk("b1_commit", 32'(state[1]), 32'd1);
        rep_cnt = 0; rep_first = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (ev_if.ev_valid && ev_if.ev_kind == EV_REPEAT && ev_if.ev_code == 3'd1) begin
                rep_cnt++;
                if (rep_first == 0) rep_first = i;
            end
        end
`ifdef BTN_REPEAT_EN
        chk("rep_count", 32'(rep_cnt), 32'd3);
        chk("rep_first", 32'(rep_first), 32'd21);
`else
        chk("rep_count", 32'(rep_cnt), 32'd0);
`endif
        btn[1] = 1'b0;
        run(12);

        // Simultaneous change on buttons 0 and 3.
        btn[0] = 1'b1; btn[3] = 1'b1;
        run(7);
        chk("pair_first", 32'(ev_if.ev_code), 32'd0);
        step();
        chk("pair_second_v", 32'(ev_if.ev_valid), 32'd1);
        chk("pair_second", 32'(ev_if.ev_code), 32'd3);
        btn = '0;
        run(12);

        // Consumer stalled: FIFO fills, pending bits overflow.
        ready = 1'b0;
        btn = '1; run(10);
        btn = '0; run(8);
        btn = '1; run(8);
        btn = '0; run(8);
        chk("ovf_drop", 32'(drop_cnt), 32'd6);
        ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            chk("drain_v", 32'(ev_if.ev_valid), 32'd1);
            chk("drain_code", 32'(ev_if.ev_code), 32'(drain_exp[i].code));
            chk("drain_kind", 32'(ev_if.ev_kind), 32'(drain_exp[i].kind));
            step();
        end
        chk("drain_empty", 32'(ev_if.ev_valid), 32'd0);
        run(3);

        // Reset with queued events and button 4 held.
        ready = 1'b0;
        btn[0] = 1'b1; run(8);
        btn[0] = 1'b0; run(8);
        chk("q2_valid", 32'(ev_if.ev_valid), 32'd1);
        btn[4] = 1'b1; run(3);
        rst = 1'b1; step();
        chk("rst_mid_valid", 32'(ev_if.ev_valid), 32'd0);
        chk("rst_mid_state", 32'(state), 32'd0);
        rst = 1'b0; ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("b4_pre", 32'(state[4]), 32'd0);
        end
        step();
        chk("b4_commit", 32'(state[4]), 32'd1);
        step();
        chk("b4_v", 32'(ev_if.ev_valid), 32'd1);
        chk("b4_code", 32'(ev_if.ev_code), 32'd4);
        chk("b4_kind", 32'(ev_if.ev_kind), 32'd0);
        btn[4] = 1'b0;
        run(10);

        // Random activity against the model.
        for (int b = 0; b < N; b++) tmr[b] = $urandom_range(1, 40);
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if (tmr[b] == 0) begin
                    btn[b] = ~btn[b];
                    tmr[b] = $urandom_range(1, 40);
                end else begin
                    tmr[b]--;
                end
            end
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
